// File: rtl/rect_plot_engine.sv
// -----------------------------------------------------------------------------
// rect_plot_engine
//
// Pixel-writer FSM that sits in front of the vga_adapter plot port. A start
// request latches a rectangle (or the whole screen in CLEAR mode), clips it
// against the visible area and then emits one pixel per clock in row-major
// order (x fastest). Busy covers the whole operation; done pulses for one
// cycle after the last pixel or after an abort.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-low
//   start         request, sampled only in IDLE
//   mode          0 = RECT, 1 = CLEAR (sampled with start)
//   x0, y0        rectangle origin
//   w, h          rectangle size in pixels
//   colour_in     RECT colour
//   clear_colour  CLEAR colour
//   abort         terminates the running operation
//   x, y, colour  pixel to the vga_adapter (valid while plot = 1)
//   plot          write strobe
//   busy          operation in progress
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module rect_plot_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           mode,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic [C_W-1:0] colour_in,
    input  logic [C_W-1:0] clear_colour,
    input  logic           abort,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    // Screen limits carried one bit wider than the coordinates so the
    // clipping subtraction and comparison can never wrap.
    localparam logic [X_W:0] LP_SCREEN_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] LP_SCREEN_H = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // State and latched operation
    state_t         r_state;
    logic [X_W-1:0] r_xs;       // first column of every row
    logic [X_W-1:0] r_xend;     // last column
    logic [Y_W-1:0] r_yend;     // last row
    logic [X_W-1:0] r_cx;       // next pixel to emit
    logic [Y_W-1:0] r_cy;
    logic [C_W-1:0] r_col;
    logic           r_more;     // at least one pixel still to emit

    // Registered outputs
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [C_W-1:0] r_colour;
    logic           r_plot;
    logic           r_busy;
    logic           r_done;

    // Operand selection and clipping
    logic [X_W:0]   w_src_x0, w_src_w, w_rem_w, w_weff;
    logic [Y_W:0]   w_src_y0, w_src_h, w_rem_h, w_heff;
    logic [C_W-1:0] w_src_col;
    logic [X_W-1:0] w_xend;
    logic [Y_W-1:0] w_yend;
    logic           w_empty;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_src_x0  = mode ? '0          : {1'b0, x0};
        w_src_y0  = mode ? '0          : {1'b0, y0};
        w_src_w   = mode ? LP_SCREEN_W : {1'b0, w};
        w_src_h   = mode ? LP_SCREEN_H : {1'b0, h};
        w_src_col = mode ? clear_colour : colour_in;

        w_rem_w = (w_src_x0 >= LP_SCREEN_W) ? '0 : LP_SCREEN_W - w_src_x0;
        w_rem_h = (w_src_y0 >= LP_SCREEN_H) ? '0 : LP_SCREEN_H - w_src_y0;
        w_weff  = (w_src_w < w_rem_w) ? w_src_w : w_rem_w;
        w_heff  = (w_src_h < w_rem_h) ? w_src_h : w_rem_h;
        w_empty = (w_weff == '0) || (w_heff == '0);

        // Only meaningful when the clipped area is non-empty; then the end
        // coordinate is inside the screen and fits the coordinate width.
        w_xend = w_src_x0[X_W-1:0] + w_weff[X_W-1:0] - X_W'(1);
        w_yend = w_src_y0[Y_W-1:0] + w_heff[Y_W-1:0] - Y_W'(1);
    end

    // Next-state and next-output logic
    state_t         w_state_nxt;
    logic [X_W-1:0] w_xs_nxt, w_xend_nxt, w_cx_nxt, w_x_nxt;
    logic [Y_W-1:0] w_yend_nxt, w_cy_nxt, w_y_nxt;
    logic [C_W-1:0] w_col_nxt, w_colour_nxt;
    logic           w_more_nxt, w_plot_nxt;
    logic           w_last;

    always_comb begin
        w_state_nxt  = r_state;
        w_xs_nxt     = r_xs;
        w_xend_nxt   = r_xend;
        w_yend_nxt   = r_yend;
        w_cx_nxt     = r_cx;
        w_cy_nxt     = r_cy;
        w_col_nxt    = r_col;
        w_more_nxt   = r_more;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_last       = (r_cx == r_xend) && (r_cy == r_yend);

        case (r_state)
            S_IDLE: begin
                // abort has no meaning here; start always wins.
                if (start) begin
                    w_xs_nxt    = w_src_x0[X_W-1:0];
                    w_cx_nxt    = w_src_x0[X_W-1:0];
                    w_cy_nxt    = w_src_y0[Y_W-1:0];
                    w_xend_nxt  = w_xend;
                    w_yend_nxt  = w_yend;
                    w_col_nxt   = w_src_col;
                    w_more_nxt  = 1'b1;
                    w_state_nxt = w_empty ? S_FIN : S_DRAW;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    w_state_nxt = S_FIN;
                end else if (r_more) begin
                    w_x_nxt      = r_cx;
                    w_y_nxt      = r_cy;
                    w_colour_nxt = r_col;
                    w_plot_nxt   = 1'b1;
                    if (w_last) begin
                        w_more_nxt = 1'b0;
                    end else if (r_cx == r_xend) begin
                        w_cx_nxt = r_xs;
                        w_cy_nxt = r_cy + Y_W'(1);
                    end else begin
                        w_cx_nxt = r_cx + X_W'(1);
                    end
                end else begin
                    // Last pixel is on the outputs this cycle.
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: reset is tested inside the clocked block, which makes it synchronous.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_xs     <= '0;
            r_xend   <= '0;
            r_yend   <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_col    <= '0;
            r_more   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state  <= w_state_nxt;
            r_xs     <= w_xs_nxt;
            r_xend   <= w_xend_nxt;
            r_yend   <= w_yend_nxt;
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
            r_col    <= w_col_nxt;
            r_more   <= w_more_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            // Status flags follow the state being entered, so they line up
            // with the state they describe.
            r_busy   <= (w_state_nxt == S_DRAW);
            r_done   <= (w_state_nxt == S_FIN);
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rect_plot_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_plot_engine
//
// Self-checking bench for rect_plot_engine. Each request pushes its expected
// pixel stream to a scoreboard queue; pixels are popped and compared as the
// DUT plots them. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rect_plot_engine;

    localparam int SW = 160;
    localparam int SH = 120;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour_in;
    logic [2:0] clear_colour;
    logic       abort;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rect_plot_engine dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .x0           (x0),
        .y0           (y0),
        .w            (w),
        .h            (h),
        .colour_in    (colour_in),
        .clear_colour (clear_colour),
        .abort        (abort),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: clip and enumerate the expected pixels.
    task automatic push_expected(input bit m, input int ax0, input int ay0, input int aw,
                                 input int ah, input int ac, input int acl, output int n);
        int ex0, ey0, ew, eh, ec, weff, heff;
        pix_t p;
        if (m) begin
            ex0 = 0; ey0 = 0; ew = SW; eh = SH; ec = acl;
        end else begin
            ex0 = ax0; ey0 = ay0; ew = aw; eh = ah; ec = ac;
        end
        weff = (ex0 >= SW) ? 0 : ((ew < SW - ex0) ? ew : SW - ex0);
        heff = (ey0 >= SH) ? 0 : ((eh < SH - ey0) ? eh : SH - ey0);
        n = weff * heff;
        for (int yy = ey0; yy < ey0 + heff; yy++) begin
            for (int xx = ex0; xx < ex0 + weff; xx++) begin
                p.px = 8'(xx);
                p.py = 7'(yy);
                p.pc = 3'(ec);
                exp_q.push_back(p);
            end
        end
    endtask

    // Drives the start edge, scrambles the operands afterwards and checks the
    // cycle that follows it. Returns with time at that cycle's falling edge.
    task automatic launch(input bit m, input int ax0, input int ay0, input int aw, input int ah,
                          input int ac, input int acl, input bit hold_start,
                          input bit abort_with_start, output int n);
        push_expected(m, ax0, ay0, aw, ah, ac, acl, n);
        @(negedge clock);
        start        = 1'b1;
        mode         = m;
        x0           = 8'(ax0);
        y0           = 7'(ay0);
        w            = 8'(aw);
        h            = 7'(ah);
        colour_in    = 3'(ac);
        clear_colour = 3'(acl);
        abort        = abort_with_start;
        @(negedge clock);
        if (n == 0) check("zero_done_busy_plot", {done, busy, plot}, 3'b100);
        else        check("setup_done_busy_plot", {done, busy, plot}, 3'b010);
        if (!hold_start) start = 1'b0;
        abort        = 1'b0;
        mode         = 1'($urandom);
        x0           = 8'($urandom);
        y0           = 7'($urandom);
        w            = 8'($urandom);
        h            = 7'($urandom);
        colour_in    = 3'($urandom);
        clear_colour = 3'($urandom);
    endtask

    // Consumes k pixels, requiring plot on every one of the k cycles.
    task automatic consume(input int k);
        pix_t p;
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            if (plot !== 1'b1 || exp_q.size() == 0) begin
                check("plot_run", {31'd0, plot}, 32'd1);
                exp_q.delete();
                break;
            end
            p = exp_q.pop_front();
            check("pixel", {busy, done, x, y, colour}, {2'b10, p});
        end
    endtask

    task automatic run_op(input bit m, input int ax0, input int ay0, input int aw, input int ah,
                          input int ac, input int acl, input bit hold_start,
                          input bit abort_with_start);
        int n;
        launch(m, ax0, ay0, aw, ah, ac, acl, hold_start, abort_with_start, n);
        if (n > 0) begin
            consume(n);
            @(negedge clock);
            check("done_pulse", {done, busy, plot}, 3'b100);
        end
        start = 1'b0;
        check("queue_empty", exp_q.size(), 0);
        @(negedge clock);
        check("idle_after_done", {done, busy, plot}, 3'b000);
    endtask

    initial begin
        int n;
        int bad;

        reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        x0 = 8'd77; y0 = 7'd33; w = 8'd9; h = 7'd9;
        colour_in = 3'd7; clear_colour = 3'd7;
        repeat (3) @(negedge clock);
        check("reset_outputs", {x, y, colour, plot, busy, done}, 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {x, y, colour, plot, busy, done}, 0);

        // Basic 4x4 square and clipped corner square
        run_op(1'b0, 10, 20, 4, 4, 5, 0, 1'b0, 1'b0);
        run_op(1'b0, 158, 118, 4, 4, 2, 0, 1'b0, 1'b0);

        // Full-screen clear; origin/size operands must be ignored
        run_op(1'b1, 33, 44, 0, 0, 6, 0, 1'b0, 1'b0);

        // Abort in IDLE does nothing
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle", {done, busy, plot}, 3'b000);

        // Abort after the 100th pixel of a clear
        launch(1'b1, 0, 0, 0, 0, 0, 3, 1'b0, 1'b0, n);
        consume(100);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_done", {done, busy, plot}, 3'b100);
        exp_q.delete();
        @(negedge clock);
        check("abort_idle_after", {done, busy, plot}, 3'b000);
        run_op(1'b0, 5, 5, 1, 1, 4, 0, 1'b0, 1'b0);

        // start held high while busy must not queue a second operation
        run_op(1'b0, 20, 30, 5, 3, 7, 0, 1'b1, 1'b0);

        // Empty rectangles: zero width, origin off-screen, zero height
        run_op(1'b0, 40, 40, 0, 3, 1, 0, 1'b0, 1'b0);
        run_op(1'b0, 170, 10, 4, 4, 1, 0, 1'b0, 1'b0);
        run_op(1'b0, 3, 119, 2, 0, 1, 0, 1'b0, 1'b0);

        // abort together with start in IDLE: start wins
        run_op(1'b0, 0, 0, 3, 2, 4, 0, 1'b0, 1'b1);

        // Reset in the middle of a rectangle
        launch(1'b0, 0, 0, 50, 50, 1, 0, 1'b0, 1'b0, n);
        consume(10);
        reset = 1'b0;
        @(negedge clock);
        check("mid_reset_outputs", {x, y, colour, plot, busy, done}, 0);
        reset = 1'b1;
        exp_q.delete();
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (done || plot || busy) bad++;
        end
        check("no_activity_after_reset", bad, 0);
        run_op(1'b0, 1, 2, 2, 1, 6, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
